// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// in system-clock cycles, with a no-edge timeout.
// Define PWM_CAPTURE_DUTY_EN to build the sequential duty-cycle divider;
// without it duty and duty_valid are tied to zero.
module pwm_capture #(
    parameter int CLK_MHZ      = 50,
    parameter int MIN_FREQ_KHZ = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic [6:0]       duty,
    output logic             duty_valid
);

    localparam int               TIMEOUT_CYC = 1000 * CLK_MHZ / MIN_FREQ_KHZ;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYC);

    // The saturation value must be representable in the counter.
    if ((TIMEOUT_CYC >> CNT_W) != 0) begin : g_cnt_w_check
        $error("pwm_capture: TIMEOUT_CYC does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sprev_q, sprev_d;
    logic             rise, fall, tmo_hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    state_t           state_q, state_d;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        sprev_d = sync2_q;
    end

    assign rise    = sync2_q & ~sprev_q;
    assign fall    = ~sync2_q & sprev_q;
    // A rise in the saturation cycle still counts as a normal edge.
    assign tmo_hit = (cnt_q == TIMEOUT_CNT) && !rise;

    // Cycle counter restarted by each rise and latched into hi_lat on each fall
    always_comb begin
        cnt_d    = cnt_q;
        hi_lat_d = hi_lat_q;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TIMEOUT_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (fall) begin
            hi_lat_d = cnt_q;
        end
    end

    // Measurement FSM: the first rise only arms, later rises publish a period
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        if (rise) begin
            timeout_d = 1'b0;
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                default: begin
                    period_d    = cnt_q;
                    high_time_d = hi_lat_q;
                    valid_d     = 1'b1;
                    state_d     = RUN;
                end
            endcase
        end else if (tmo_hit) begin
            timeout_d   = 1'b1;
            period_d    = '0;
            high_time_d = '0;
            state_d     = IDLE;
        end
    end

    // Synchronizer, counter, measurement and state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sprev_q     <= 1'b0;
            cnt_q       <= '0;
            hi_lat_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            state_q     <= IDLE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sprev_q     <= sprev_d;
            cnt_q       <= cnt_d;
            hi_lat_q    <= hi_lat_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            state_q     <= state_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

`ifdef PWM_CAPTURE_DUTY_EN
    localparam int Q_W  = CNT_W + 7;
    localparam int IT_W = $clog2(Q_W + 1);

    logic             busy_q, busy_d;
    logic [IT_W-1:0]  it_q, it_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dsr_q, dsr_d;
    logic [6:0]       duty_q, duty_d;
    logic             dv_q, dv_d;
    logic [CNT_W:0]   rem_shift;
    logic [CNT_W:0]   rem_sub;

    // Clamp the quotient to a percentage; only reachable with a zero divisor.
    function automatic logic [6:0] sat_duty(input logic [Q_W-1:0] q);
        if (q > Q_W'(100)) begin
            return 7'd100;
        end
        return q[6:0];
    endfunction

    // Restoring divider, one quotient bit per cycle; a new valid restarts it
    // with fresh operands so a stale quotient is never strobed.
    always_comb begin
        busy_d    = busy_q;
        it_d      = it_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        duty_d    = duty_q;
        dv_d      = 1'b0;
        rem_shift = {rem_q, quo_q[Q_W-1]};
        rem_sub   = rem_shift - {1'b0, dsr_q};
        if (tmo_hit) begin
            busy_d = 1'b0;
            duty_d = '0;
        end else if (valid_q) begin
            busy_d = 1'b1;
            it_d   = IT_W'(Q_W);
            quo_d  = Q_W'(high_time_q) * Q_W'(100);
            rem_d  = '0;
            dsr_d  = period_q;
        end else if (busy_q) begin
            if (rem_shift >= {1'b0, dsr_q}) begin
                rem_d = rem_sub[CNT_W-1:0];
                quo_d = {quo_q[Q_W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[CNT_W-1:0];
                quo_d = {quo_q[Q_W-2:0], 1'b0};
            end
            it_d = it_q - IT_W'(1);
            if (it_q == IT_W'(1)) begin
                busy_d = 1'b0;
                duty_d = sat_duty(quo_d);
                dv_d   = 1'b1;
            end
        end
    end

    // Divider registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            it_q   <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            duty_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            it_q   <= it_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            duty_q <= duty_d;
            dv_q   <= dv_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = dv_q;
`else
    assign duty       = 7'd0;
    assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture at default parameters.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        timeout;
    logic [6:0]  duty;
    logic        duty_valid;

    int n_vec = 0;
    int n_err = 0;

    // Strobe log filled by the monitor
    int          cyc = 0;
    int          nv = 0;
    int          nd = 0;
    int          last_v_cyc = 0;
    int          last_d_cyc = 0;
    bit          x_seen = 1'b0;
    logic [15:0] per_log [256];
    logic [15:0] hi_log  [256];

    always #5 clk = ~clk;

    pwm_capture #(
        .CLK_MHZ(50),
        .MIN_FREQ_KHZ(1),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in),
        .period(period),
        .high_time(high_time),
        .valid(valid),
        .timeout(timeout),
        .duty(duty),
        .duty_valid(duty_valid)
    );

    // Record every strobe and any unknown output value
    always @(negedge clk) begin
        cyc = cyc + 1;
        if ($isunknown({period, high_time, valid, timeout, duty, duty_valid}))
            x_seen = 1'b1;
        if (valid === 1'b1) begin
            if (nv < 256) begin
                per_log[nv] = period;
                hi_log[nv]  = high_time;
            end
            nv = nv + 1;
            last_v_cyc = cyc;
        end
        if (duty_valid === 1'b1) begin
            nd = nd + 1;
            last_d_cyc = cyc;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pwm(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            in = 1'b1;
            repeat (hi) @(negedge clk);
            in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in  = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (period !== 16'd0) begin n_err++; $display("FAIL reset_period got %0d want 0", period); end
        n_vec++; if (high_time !== 16'd0) begin n_err++; $display("FAIL reset_high got %0d want 0", high_time); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
        n_vec++; if (duty !== 7'd0) begin n_err++; $display("FAIL reset_duty got %0d want 0", duty); end
        n_vec++; if (duty_valid !== 1'b0) begin n_err++; $display("FAIL reset_duty_valid got %b want 0", duty_valid); end
        rst = 1'b0;
    endtask

    // High 2 / low 2: valids every 4 cycles keep restarting the divider
    task automatic test_example();
        int b, bd;
        do_reset();
        b = nv; bd = nd;
        pwm(2, 2, 5);
        idle(40);
        n_vec++; if (nv - b != 4) begin n_err++; $display("FAIL ex_valid_count got %0d want 4", nv - b); end
        n_vec++; if (period !== 16'd4) begin n_err++; $display("FAIL ex_period got %0d want 4", period); end
        n_vec++; if (high_time !== 16'd2) begin n_err++; $display("FAIL ex_high got %0d want 2", high_time); end
`ifdef PWM_CAPTURE_DUTY_EN
        n_vec++; if (nd - bd != 1) begin n_err++; $display("FAIL ex_dv_count got %0d want 1", nd - bd); end
        n_vec++; if (duty !== 7'd50) begin n_err++; $display("FAIL ex_duty got %0d want 50", duty); end
`else
        n_vec++; if (nd - bd != 0) begin n_err++; $display("FAIL ex_dv_count got %0d want 0", nd - bd); end
        n_vec++; if (duty !== 7'd0) begin n_err++; $display("FAIL ex_duty got %0d want 0", duty); end
`endif
    endtask

    // 400 kHz, 40 %: 125-cycle period, 50 high
    task automatic test_400k();
        int b, bd;
        do_reset();
        b = nv; bd = nd;
        pwm(50, 75, 6);
        idle(30);
        n_vec++; if (nv - b != 5) begin n_err++; $display("FAIL k400_valid_count got %0d want 5", nv - b); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (per_log[b+i] !== 16'd125 || hi_log[b+i] !== 16'd50) begin
                n_err++;
                $display("FAIL k400_meas[%0d] got %0d/%0d want 125/50", i, per_log[b+i], hi_log[b+i]);
            end
        end
`ifdef PWM_CAPTURE_DUTY_EN
        n_vec++; if (nd - bd != 5) begin n_err++; $display("FAIL k400_dv_count got %0d want 5", nd - bd); end
        n_vec++; if (duty !== 7'd40) begin n_err++; $display("FAIL k400_duty got %0d want 40", duty); end
        n_vec++; if (last_d_cyc - last_v_cyc != 24) begin n_err++; $display("FAIL k400_dv_latency got %0d want 24", last_d_cyc - last_v_cyc); end
`else
        n_vec++; if (nd - bd != 0) begin n_err++; $display("FAIL k400_dv_count got %0d want 0", nd - bd); end
        n_vec++; if (duty !== 7'd0) begin n_err++; $display("FAIL k400_duty got %0d want 0", duty); end
`endif
    endtask

    // 125 -> 200 cycle period switch, high 50 -> 150
    task automatic test_period_change();
        int b;
        logic [15:0] wp, wh;
        do_reset();
        b = nv;
        pwm(50, 75, 3);
        pwm(150, 50, 3);
        idle(30);
        n_vec++; if (nv - b != 5) begin n_err++; $display("FAIL chg_valid_count got %0d want 5", nv - b); end
        for (int i = 0; i < 5; i++) begin
            wp = (i < 3) ? 16'd125 : 16'd200;
            wh = (i < 3) ? 16'd50  : 16'd150;
            n_vec++;
            if (per_log[b+i] !== wp || hi_log[b+i] !== wh) begin
                n_err++;
                $display("FAIL chg_meas[%0d] got %0d/%0d want %0d/%0d", i, per_log[b+i], hi_log[b+i], wp, wh);
            end
        end
`ifdef PWM_CAPTURE_DUTY_EN
        n_vec++; if (duty !== 7'd75) begin n_err++; $display("FAIL chg_duty got %0d want 75", duty); end
`else
        n_vec++; if (duty !== 7'd0) begin n_err++; $display("FAIL chg_duty got %0d want 0", duty); end
`endif
    endtask

    // Input held low until timeout, then PWM resumes
    task automatic test_timeout();
        int b;
        do_reset();
        pwm(50, 75, 3);
        idle(5);
`ifdef PWM_CAPTURE_DUTY_EN
        n_vec++; if (duty !== 7'd40) begin n_err++; $display("FAIL tmo_pre_duty got %0d want 40", duty); end
`endif
        b = nv;
        // Last rise is processed about 123 cycles before the low phase starts.
        idle(49840);
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_early got %b want 0", timeout); end
        idle(100);
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_set got %b want 1", timeout); end
        n_vec++; if (period !== 16'd0 || high_time !== 16'd0) begin n_err++; $display("FAIL tmo_clear_meas got %0d/%0d want 0/0", period, high_time); end
        n_vec++; if (duty !== 7'd0) begin n_err++; $display("FAIL tmo_duty got %0d want 0", duty); end
        n_vec++; if (nv != b) begin n_err++; $display("FAIL tmo_no_valid got %0d want %0d", nv, b); end
        pwm(50, 75, 1);
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_release got %b want 0", timeout); end
        n_vec++; if (nv != b) begin n_err++; $display("FAIL tmo_first_discard got %0d want %0d", nv, b); end
        pwm(50, 75, 2);
        idle(5);
        n_vec++; if (nv - b != 2) begin n_err++; $display("FAIL tmo_resume_count got %0d want 2", nv - b); end
        n_vec++; if (period !== 16'd125 || high_time !== 16'd50) begin n_err++; $display("FAIL tmo_resume_meas got %0d/%0d want 125/50", period, high_time); end
    endtask

    // Reset while a period and a division are in flight
    task automatic test_reset_mid();
        int b, bd;
        do_reset();
        pwm(50, 75, 2);
        in = 1'b1;
        idle(10);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (period !== 16'd0 || high_time !== 16'd0) begin n_err++; $display("FAIL mid_meas got %0d/%0d want 0/0", period, high_time); end
        n_vec++; if (valid !== 1'b0 || duty_valid !== 1'b0) begin n_err++; $display("FAIL mid_strobes got %b/%b want 0/0", valid, duty_valid); end
        n_vec++; if (timeout !== 1'b0 || duty !== 7'd0) begin n_err++; $display("FAIL mid_tmo_duty got %b/%0d want 0/0", timeout, duty); end
        rst = 1'b0;
        b = nv; bd = nd;
        idle(40);
        in = 1'b0;
        idle(75);
        idle(30);
        n_vec++; if (nv != b) begin n_err++; $display("FAIL mid_no_valid got %0d want %0d", nv, b); end
        n_vec++; if (nd != bd) begin n_err++; $display("FAIL mid_no_dv got %0d want %0d", nd, bd); end
        pwm(50, 75, 1);
        idle(5);
        n_vec++; if (nv - b != 1) begin n_err++; $display("FAIL mid_second_rise got %0d want 1", nv - b); end
    endtask

    // Edges placed within +/-9 time units of clock edges
    task automatic test_jitter();
        int b, cur, tgt, e;
        do_reset();
        b = nv;
        @(negedge clk);
        #5;
        cur = 0;
        for (int k = 0; k < 9; k++) begin
            e   = int'($urandom_range(18)) - 9;
            tgt = 100 + 1250 * k + e;
            #(tgt - cur);
            cur = tgt;
            in  = 1'b1;
            e   = int'($urandom_range(18)) - 9;
            tgt = 100 + 1250 * k + 500 + e;
            #(tgt - cur);
            cur = tgt;
            in  = 1'b0;
        end
        idle(100);
        n_vec++; if (nv - b != 8) begin n_err++; $display("FAIL jit_valid_count got %0d want 8", nv - b); end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (per_log[b+i] < 16'd123 || per_log[b+i] > 16'd127 ||
                hi_log[b+i] < 16'd48 || hi_log[b+i] > 16'd52) begin
                n_err++;
                $display("FAIL jit_meas[%0d] got %0d/%0d want 125+/-2 / 50+/-2", i, per_log[b+i], hi_log[b+i]);
            end
        end
        n_vec++; if (x_seen) begin n_err++; $display("FAIL jit_no_x got x_seen=1 want 0"); end
    endtask

    initial begin
        rst = 1'b1;
        in  = 1'b0;
        test_reset();
        test_example();
        test_400k();
        test_period_change();
        test_timeout();
        test_reset_mid();
        test_jitter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
